// File: rtl/mem_pkg.sv
// Shared definitions for banked_data_ram: access-size codes, FSM states and the
// byte-lane mask helper.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int MAX_LANES = 16;
  localparam int MAX_OFF_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Reserved size 2'b11 behaves as a full word: every lane enabled.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [MAX_OFF_W-1:0] off);
    logic [MAX_LANES-1:0] m;
    case (size)
      SIZE_BYTE: m = MAX_LANES'(1) << off;
      SIZE_HALF: m = MAX_LANES'(3) << off;
      default:   m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/banked_data_ram_bank.sv
// One byte lane of banked_data_ram: DEPTH x 8 single-port synchronous RAM.
// Contents are never reset; read data is registered and holds between reads.
module ram_bank #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_data_ram.sv
// Byte-banked data RAM with req/ack handshake, wait states, sized loads/stores.
// Optional MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning them down.
//
// state  | meaning
// IDLE   | ready_o high, waiting for req_i
// WAIT   | burning WAIT_CYCLES stall cycles
// ACCESS | banks read or written
// RESP   | bank data formatted; ack_o rises on the next edge
module banked_data_ram
  import mem_pkg::*;
#(
  parameter  int NUM_BANKS   = 4,
  parameter  int DEPTH       = 1024,
  parameter  int ADDR_W      = 32,
  parameter  int WAIT_CYCLES = 0,
  localparam int DATA_W      = 8 * NUM_BANKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int OFF_W = $clog2(NUM_BANKS);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LA_W  = OFF_W + IDX_W;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                we_q;
  logic                signed_q;
  logic [1:0]          size_q;
  logic [LA_W-1:0]     addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                accept;
  logic [OFF_W-1:0]    raw_off;
  logic [OFF_W-1:0]    eff_off;
  logic                trap;
  logic [IDX_W-1:0]    word_idx;
  logic [MAX_LANES-1:0] mask_full;
  logic [NUM_BANKS-1:0] lane_en;
  logic [DATA_W-1:0]   wdata_sh;
  logic [DATA_W-1:0]   bank_rdata;
  logic [DATA_W-1:0]   rd_sh;
  logic [DATA_W-1:0]   load_val;
  logic                bank_en;
  logic [NUM_BANKS-1:0] bank_we;
  logic                unused_addr_hi;

  // Upper address bits only alias; they are intentionally dropped.
  assign unused_addr_hi = ^addr_i[ADDR_W-1:LA_W];

  assign ready_o = (state_q == IDLE);
  assign accept  = req_i && ready_o;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= we_i;
      signed_q <= signed_i;
      size_q   <= size_i;
      addr_q   <= addr_i[LA_W-1:0];
      wdata_q  <= wdata_i;
    end
  end

  assign raw_off  = addr_q[OFF_W-1:0];
  assign word_idx = addr_q[LA_W-1:OFF_W];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    eff_off = raw_off;
    case (size_q)
      SIZE_BYTE: trap = 1'b0;
      SIZE_HALF: trap = raw_off[0];
      default:   trap = (raw_off != '0);
    endcase
  end
`else
  always_comb begin
    trap = 1'b0;
    case (size_q)
      SIZE_BYTE: eff_off = raw_off;
      SIZE_HALF: eff_off = {raw_off[OFF_W-1:1], 1'b0};
      default:   eff_off = '0;
    endcase
  end
`endif

  assign mask_full = lane_mask(size_q, MAX_OFF_W'(eff_off));
  assign lane_en   = mask_full[NUM_BANKS-1:0];
  assign wdata_sh  = wdata_q << {eff_off, 3'b000};
  assign rd_sh     = bank_rdata >> {eff_off, 3'b000};

  always_comb begin
    case (size_q)
      SIZE_BYTE: load_val = signed_q ? {{(DATA_W-8){rd_sh[7]}}, rd_sh[7:0]}
                                     : {{(DATA_W-8){1'b0}}, rd_sh[7:0]};
      SIZE_HALF: load_val = signed_q ? {{(DATA_W-16){rd_sh[15]}}, rd_sh[15:0]}
                                     : {{(DATA_W-16){1'b0}}, rd_sh[15:0]};
      default:   load_val = bank_rdata;
    endcase
  end

  // A reset arriving in the ACCESS cycle still blocks the write.
  assign bank_en = (state_q == ACCESS);
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_we[i] = bank_en && we_q && !trap && lane_en[i] && !rst;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    ram_bank #(.DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .en_i    (bank_en),
      .we_i    (bank_we[g]),
      .addr_i  (word_idx),
      .wdata_i (wdata_sh[8*g +: 8]),
      .rdata_o (bank_rdata[8*g +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        ack_d   = 1'b1;
        err_d   = trap;
        rdata_d = (we_q || trap) ? '0 : load_val;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_banked_data_ram.sv
// Directed bench for banked_data_ram: three instances with 0, 3 and 4 wait states
// sharing the request fields; expectations follow MISALIGN_TRAP_EN when defined.
module tb_banked_data_ram;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ready;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rdata [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  banked_data_ram #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready[0]), .ack_o(ack[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  banked_data_ram #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready[1]), .ack_o(ack[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  banked_data_ram #(.WAIT_CYCLES(4)) u_dut2 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready[2]), .ack_o(ack[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic access(input int sel, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    we = w; size = sz; sgn = sg; addr = a; wdata = wd;
    req[sel] = 1'b1;
    guard = 0;
    while (!ready[sel] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req[sel] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack[sel] && lat < 50);
    rd = rdata[sel];
    er = err[sel];
  endtask

  task automatic store(input int sel, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_lat, input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(sel, 1'b1, sz, 1'b0, a, wd, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic load(input int sel, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(sel, 1'b0, sz, sg, a, 32'h0, rd, er, lat);
    chk(tag, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acks;

    rst = 1'b1; req = '0; we = 1'b0; size = SIZE_WORD; sgn = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'b0, ready[0]}, 32'h1);
    chk("rst_ready2", {31'b0, ready[2]}, 32'h1);
    chk("rst_ack0",   {31'b0, ack[0]},   32'h0);
    chk("rst_err0",   {31'b0, err[0]},   32'h0);
    chk("rst_rdata0", rdata[0],          32'h0);
    rst = 1'b0;

    // word store / load, individual lanes
    store(0, SIZE_WORD, 32'h0, 32'h1122_3344, 2, "st_w0");
    load(0, SIZE_WORD, 1'b0, 32'h0, 32'h1122_3344, "ld_w0");
    load(0, SIZE_BYTE, 1'b0, 32'h0, 32'h0000_0044, "ld_lane0");
    load(0, SIZE_BYTE, 1'b0, 32'h3, 32'h0000_0011, "ld_lane3");

    // byte store and extension
    store(0, SIZE_WORD, 32'h4, 32'h5566_7788, 2, "st_w4");
    store(0, SIZE_BYTE, 32'h5, 32'hAAAA_AAF0, 2, "st_b5");
    load(0, SIZE_BYTE, 1'b1, 32'h5, 32'hFFFF_FFF0, "ld_b5_s");
    load(0, SIZE_BYTE, 1'b0, 32'h5, 32'h0000_00F0, "ld_b5_u");
    load(0, SIZE_WORD, 1'b0, 32'h4, 32'h5566_F088, "ld_w4");

    // half store and extension
    store(0, SIZE_WORD, 32'h8, 32'h0000_0000, 2, "st_w8");
    store(0, SIZE_HALF, 32'hA, 32'h1234_8001, 2, "st_hA");
    load(0, SIZE_HALF, 1'b1, 32'hA, 32'hFFFF_8001, "ld_hA_s");
    load(0, SIZE_HALF, 1'b0, 32'hA, 32'h0000_8001, "ld_hA_u");
    load(0, SIZE_WORD, 1'b0, 32'h8, 32'h8001_0000, "ld_w8");
    load(0, SIZE_BYTE, 1'b1, 32'hA, 32'h0000_0001, "ld_bA_s_pos");
    load(0, SIZE_WORD, 1'b1, 32'h4, 32'h5566_F088, "ld_w4_sign_ignored");

    // word index wraps at DEPTH words; upper bits ignored
    load(0, SIZE_WORD, 1'b0, 32'h0000_1000, 32'h1122_3344, "ld_alias_depth");
    load(0, SIZE_WORD, 1'b0, 32'h8000_0000, 32'h1122_3344, "ld_alias_hi");

    // wait states: 3 stalls -> ack 5 cycles after accept, extra req ignored
    store(1, SIZE_WORD, 32'h10, 32'hCAFE_F00D, 5, "ws_st");
    @(negedge clk);
    we = 1'b0; size = SIZE_WORD; sgn = 1'b0; addr = 32'h10; req[1] = 1'b1;
    @(posedge clk);
    #1 addr = 32'h14;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      chk("ws_ready_low", {31'b0, ready[1]}, 32'h0);
      chk("ws_ack_low",   {31'b0, ack[1]},   32'h0);
    end
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("ws_ack_at5", {31'b0, ack[1]}, 32'h1);
    chk("ws_rdata",   rdata[1],        32'hCAFE_F00D);
    acks = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ack[1]) acks++;
    end
    chk("ws_no_extra_ack", 32'(acks), 32'h0);
    chk("ws_rdata_hold",   rdata[1],  32'hCAFE_F00D);

    // misaligned accesses
    access(0, 1'b1, SIZE_WORD, 1'b0, 32'h2, 32'hDEAD_BEEF, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
    chk("mis_st_err", {31'b0, er}, 32'h1);
    load(0, SIZE_WORD, 1'b0, 32'h0, 32'h1122_3344, "mis_st_word0");
    load(0, SIZE_BYTE, 1'b0, 32'h1, 32'h0000_0033, "mis_byte1");
    access(0, 1'b0, SIZE_HALF, 1'b0, 32'h1, 32'h0, rd, er, lat);
    chk("mis_ld_rdata", rd, 32'h0);
    chk("mis_ld_err", {31'b0, er}, 32'h1);
`else
    chk("mis_st_err", {31'b0, er}, 32'h0);
    load(0, SIZE_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, "mis_st_word0");
    load(0, SIZE_BYTE, 1'b0, 32'h1, 32'h0000_00BE, "mis_byte1");
    access(0, 1'b0, SIZE_HALF, 1'b0, 32'h1, 32'h0, rd, er, lat);
    chk("mis_ld_rdata", rd, 32'h0000_BEEF);
    chk("mis_ld_err", {31'b0, er}, 32'h0);
`endif

    // reset during WAIT aborts the store before it touches the banks
    store(2, SIZE_WORD, 32'h20, 32'h0102_0304, 6, "rs_st");
    @(negedge clk);
    we = 1'b1; size = SIZE_WORD; sgn = 1'b0; addr = 32'h20; wdata = 32'hFFFF_FFFF;
    req[2] = 1'b1;
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rs_ready", {31'b0, ready[2]}, 32'h1);
    chk("rs_ack",   {31'b0, ack[2]},   32'h0);
    acks = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ack[2]) acks++;
    end
    chk("rs_no_ack", 32'(acks), 32'h0);
    load(2, SIZE_WORD, 1'b0, 32'h20, 32'h0102_0304, "rs_word_kept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
